// File: rtl/spi_master_mcs_if.sv
// Host-side control/status bundle for spi_master_mcs (config, TX push, RX pop, flags).
// Latency: none, wires only.
// Backpressure: the host watches tx_full/rx_empty; pushes to a full TX FIFO are ignored.
// Ports (fields): enable, cpol, cpha, prescaler, cs_sel, hold_cs, loopback, tx_data, tx_wr,
//   rx_rd (host -> core); rx_data, tx_full, tx_empty, rx_full, rx_empty, busy, done,
//   rx_ovf (core -> host).
// Modports: master = register wrapper side, slave = SPI core side.
interface spi_master_mcs_if #(
  parameter int DW     = 8,
  parameter int NUM_CS = 2
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic           enable;
  logic           cpol;
  logic           cpha;
  logic [7:0]     prescaler;
  logic [CSW-1:0] cs_sel;
  logic           hold_cs;
  logic           loopback;
  logic [DW-1:0]  tx_data;
  logic           tx_wr;
  logic           rx_rd;
  logic [DW-1:0]  rx_data;
  logic           tx_full;
  logic           tx_empty;
  logic           rx_full;
  logic           rx_empty;
  logic           busy;
  logic           done;
  logic           rx_ovf;

  modport master (
    output enable, cpol, cpha, prescaler, cs_sel, hold_cs, loopback, tx_data, tx_wr, rx_rd,
    input  rx_data, tx_full, tx_empty, rx_full, rx_empty, busy, done, rx_ovf
  );

  modport slave (
    input  enable, cpol, cpha, prescaler, cs_sel, hold_cs, loopback, tx_data, tx_wr, rx_rd,
    output rx_data, tx_full, tx_empty, rx_full, rx_empty, busy, done, rx_ovf
  );
endinterface

// File: rtl/spi_master_mcs.sv
// Parametrised SPI master: DW-bit frames, CPOL/CPHA modes, NUM_CS selects, TX/RX FIFOs.
// Latency: 1 + (prescaler+1)*(2*DW+2) clk from TX pop back to IDLE.
// Backpressure: TX push ignored when full; a frame received while RX is full is dropped (rx_ovf).
// Ports: clk, rst_n (async active-low); bus (spi_master_mcs_if.slave: control, FIFO and
//   status fields); miso (serial in); mosi, sclk, csb[NUM_CS] (active-low) outputs.
// Optional build macro SPI_LOOPBACK_EN: when defined, loopback=1 feeds mosi back into the
//   receive shifter instead of miso; otherwise the loopback field is ignored.

// Generic synchronous FIFO, first-word-fall-through read port.
// Latency: write visible at rdata the cycle after push into an empty FIFO.
// Backpressure: push when full and pop when empty are ignored.
module spi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module spi_master_mcs #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_mcs_if.slave   bus,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_CS-1:0] csb
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int EW  = $clog2(2*DW + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DW - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_n;

  logic              tx_pop, load, frame_end, rx_push;
  logic              tx_empty, rx_full;
  logic [DW-1:0]     tx_head, rx_word, rx_next;
  logic              cpol_lat, cpha_lat, new_cpha;
  logic [7:0]        pre_lat, hcnt;
  logic [EW-1:0]     ecnt;
  logic [DW-1:0]     sh_tx, sh_rx;
  logic              mosi_r, sclk_r, done_r, ovf_r;
  logic [NUM_CS-1:0] csb_r, cs_onehot;
  logic              half_end, last_edge, sample_edge, ser_in;

  // ---------------------------------------------------------------- FIFOs
  spi_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.tx_wr),
    .pop   (tx_pop),
    .wdata (bus.tx_data),
    .rdata (tx_head),
    .full  (bus.tx_full),
    .empty (tx_empty)
  );

  spi_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (bus.rx_rd),
    .wdata (rx_word),
    .rdata (bus.rx_data),
    .full  (rx_full),
    .empty (bus.rx_empty)
  );

  assign bus.tx_empty = tx_empty;
  assign bus.rx_full  = rx_full;

  // ---------------------------------------------------------- serial input
`ifdef SPI_LOOPBACK_EN
  assign ser_in = bus.loopback ? mosi_r : miso;
`else
  assign ser_in = miso;
  logic unused_loopback;
  assign unused_loopback = bus.loopback;
`endif

  // ------------------------------------------------------ timing helpers
  // ecnt counts SCK edges already issued in this frame; edge k+1 is leading
  // when k is even. Sample edges are leading for cpha=0, trailing for cpha=1.
  assign half_end    = (hcnt == pre_lat);
  assign last_edge   = (ecnt == LAST_EDGE);
  assign sample_edge = (ecnt[0] == cpha_lat);
  assign rx_next     = {sh_rx[DW-2:0], ser_in};
  // For cpha=1 the final edge is itself a sample edge, so include that bit.
  assign rx_word     = sample_edge ? rx_next : sh_rx;
  assign rx_push     = frame_end & ~rx_full;
  assign new_cpha    = load ? bus.cpha : cpha_lat;

  // Out-of-range selects fall back to CS0.
  always_comb begin
    cs_onehot = '0;
    for (int i = 0; i < NUM_CS; i++)
      if (bus.cs_sel == CSW'(i)) cs_onehot[i] = 1'b1;
    if (cs_onehot == '0) cs_onehot[0] = 1'b1;
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tx_pop    = 1'b0;
    load      = 1'b0;
    frame_end = 1'b0;
    if (!bus.enable) begin
      // Dropping enable abandons the frame without pushing RX or pulsing done.
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            load    = 1'b1;
            state_n = SETUP;
          end
        end
        SETUP: begin
          if (half_end) state_n = SHIFT;
        end
        SHIFT: begin
          if (half_end && last_edge) begin
            frame_end = 1'b1;
            state_n   = HOLD;
          end
        end
        HOLD: begin
          if (half_end) begin
            if (bus.hold_cs && !tx_empty) begin
              // Chained frame: CS and the latched mode/prescaler carry over.
              tx_pop  = 1'b1;
              state_n = SETUP;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_lat <= 1'b0;
      cpha_lat <= 1'b0;
      pre_lat  <= '0;
      hcnt     <= '0;
      ecnt     <= '0;
      sh_tx    <= '0;
      sh_rx    <= '0;
      mosi_r   <= 1'b0;
      sclk_r   <= 1'b0;
      csb_r    <= '1;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      // Registered so done/rx_ovf line up with the RX word becoming visible.
      done_r <= frame_end;
      ovf_r  <= frame_end & rx_full;

      if (tx_pop) begin
        if (load) begin
          cpol_lat <= bus.cpol;
          cpha_lat <= bus.cpha;
          pre_lat  <= bus.prescaler;
          sclk_r   <= bus.cpol;
          csb_r    <= ~cs_onehot;
        end
        hcnt  <= '0;
        ecnt  <= '0;
        sh_rx <= '0;
        if (!new_cpha) begin
          // cpha=0: MSB must be on the wire before the first (sampling) edge.
          mosi_r <= tx_head[DW-1];
          sh_tx  <= tx_head << 1;
        end else begin
          sh_tx  <= tx_head;
        end
      end else if (state_n == IDLE) begin
        csb_r  <= '1;
        sclk_r <= bus.cpol;
        hcnt   <= '0;
        ecnt   <= '0;
      end else begin
        hcnt <= half_end ? 8'd0 : hcnt + 8'd1;
        if (state == SHIFT && half_end) begin
          sclk_r <= ~sclk_r;
          ecnt   <= ecnt + 1'b1;
          if (sample_edge) begin
            sh_rx <= rx_next;
          end else if (!last_edge) begin
            // cpha=0 ends on a shift edge; keep the last bit on mosi.
            mosi_r <= sh_tx[DW-1];
            sh_tx  <= sh_tx << 1;
          end
        end
      end
    end
  end

  assign mosi       = mosi_r;
  assign sclk       = sclk_r;
  assign csb        = csb_r;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.rx_ovf = ovf_r;
endmodule
